// File: rtl/instr_exec_ctrl.sv
// Multi-cycle execute controller in front of the 8x8 register file: accepts one
// instruction per handshake, reads both operands, computes a result and issues one write-back.
module instr_exec_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_LENGTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Instr_Valid,
  input  logic [15:0]            Instruction,
  output logic                   Instr_Ready,
  output logic [ADDR_LENGTH-1:0] Read_Register_1,
  output logic [ADDR_LENGTH-1:0] Read_Register_2,
  input  logic [WORD_LENGTH-1:0] Read_Data_1,
  input  logic [WORD_LENGTH-1:0] Read_Data_2,
  output logic                   reg_Write,
  output logic [ADDR_LENGTH-1:0] Write_Register,
  output logic [WORD_LENGTH-1:0] Write_Data,
  output logic                   Done,
  output logic                   Illegal,
  output logic                   Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LI  = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   accept_s;
  logic [3:0]             opcode_r;
  logic [ADDR_LENGTH-1:0] rd_r;
  logic [ADDR_LENGTH-1:0] rs1_r;
  logic [ADDR_LENGTH-1:0] rs2_r;
  logic [7:0]             imm_r;
  logic [WORD_LENGTH-1:0] result_r;
  logic [WORD_LENGTH-1:0] alu_s;
  logic                   ready_r;
  logic                   done_r;
  logic                   illegal_r;
  logic                   write_r;
  logic                   zero_r;

  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_SHR;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; acceptance is gated by the registered ready so nothing is taken while reset settles
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (Instr_Valid && ready_r) begin
          next_state_s = READ;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ:    next_state_s = WB;
      WB:      next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Instruction field latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_r <= 4'd0;
      rd_r     <= '0;
      rs1_r    <= '0;
      rs2_r    <= '0;
      imm_r    <= 8'd0;
    end else if (accept_s) begin
      opcode_r <= Instruction[15:12];
      rd_r     <= ADDR_LENGTH'(Instruction[11:9]);
      rs1_r    <= ADDR_LENGTH'(Instruction[8:6]);
      rs2_r    <= ADDR_LENGTH'(Instruction[5:3]);
      imm_r    <= Instruction[7:0];
    end else begin
      opcode_r <= opcode_r;
    end
  end

  // Result datapath; opcodes that do not write leave the result register untouched
  always_comb begin
    alu_s = result_r;
    case (opcode_r)
      OP_ADD:  alu_s = Read_Data_1 + Read_Data_2;
      OP_SUB:  alu_s = Read_Data_1 - Read_Data_2;
      OP_AND:  alu_s = Read_Data_1 & Read_Data_2;
      OP_OR:   alu_s = Read_Data_1 | Read_Data_2;
      OP_XOR:  alu_s = Read_Data_1 ^ Read_Data_2;
      OP_LI:   alu_s = WORD_LENGTH'(imm_r);
      OP_MOV:  alu_s = Read_Data_1;
      OP_SHL:  alu_s = Read_Data_1 << Read_Data_2[2:0];
      OP_SHR:  alu_s = Read_Data_1 >> Read_Data_2[2:0];
      OP_NOP:  alu_s = result_r;
      default: alu_s = result_r;
    endcase
  end

  // Result register, loaded at the edge leaving READ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r <= '0;
    end else if ((state_r == READ) && is_write_op(opcode_r)) begin
      result_r <= alu_s;
    end else begin
      result_r <= result_r;
    end
  end

  // Registered handshake and completion outputs; write-back strobes trail the WB state by one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      write_r   <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      ready_r   <= (next_state_s == IDLE);
      done_r    <= (state_r == WB);
      illegal_r <= (state_r == WB) && is_illegal_op(opcode_r);
      write_r   <= (state_r == WB) && is_write_op(opcode_r);
      if ((state_r == WB) && is_write_op(opcode_r)) begin
        zero_r <= (result_r == '0);
      end else begin
        zero_r <= zero_r;
      end
    end
  end

  assign Instr_Ready     = ready_r;
  assign Read_Register_1 = rs1_r;
  assign Read_Register_2 = rs2_r;
  assign reg_Write       = write_r;
  assign Write_Register  = rd_r;
  assign Write_Data      = result_r;
  assign Done            = done_r;
  assign Illegal         = illegal_r;
  assign Zero            = zero_r;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// Self-checking bench for instr_exec_ctrl: drives directed and random instructions
// against a behavioural register-file/ISA model.
module tb_instr_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Instr_Valid = 1'b0;
  logic [15:0] Instruction = 16'h0000;
  logic        Instr_Ready;
  logic [2:0]  Read_Register_1, Read_Register_2;
  logic [7:0]  Read_Data_1, Read_Data_2;
  logic        reg_Write;
  logic [2:0]  Write_Register;
  logic [7:0]  Write_Data;
  logic        Done, Illegal, Zero;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] exp_rf [8] = '{default: 8'h00};
  logic [7:0] exp_last = 8'h00;
  bit         exp_zero = 1'b0;
  int         last_acc = -100;

  instr_exec_ctrl #(.WORD_LENGTH(8), .ADDR_LENGTH(3)) dut (
    .clk(clk), .reset(reset), .Instr_Valid(Instr_Valid), .Instruction(Instruction),
    .Instr_Ready(Instr_Ready), .Read_Register_1(Read_Register_1), .Read_Register_2(Read_Register_2),
    .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .reg_Write(reg_Write),
    .Write_Register(Write_Register), .Write_Data(Write_Data), .Done(Done),
    .Illegal(Illegal), .Zero(Zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file the controller talks to
  assign Read_Data_1 = rf[Read_Register_1];
  assign Read_Data_2 = rf[Read_Register_2];
  always @(posedge clk) if (reg_Write) rf[Write_Register] <= Write_Data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] enc_li(input int rd, input int imm);
    return {4'h6, 3'(rd), 1'b0, 8'(imm)};
  endfunction

  // ISA reference: plain arithmetic modulo 256
  function automatic int ref_result(input int op, input int a, input int b, input int imm);
    case (op)
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return imm;
      7: return a;
      8: return (a * (1 << (b % 8))) % 256;
      9: return a / (1 << (b % 8));
      default: return 0;
    endcase
  endfunction

  task automatic wait_ready();
    int waited = 0;
    @(negedge clk);
    while (!Instr_Ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_timeout", 32'(waited < 10), 32'd1);
  endtask

  task automatic run_instr(input logic [15:0] ins, input bit hold_valid, input bit check_gap);
    int op, rd, rs1, rs2, imm, a, b, res, acc;
    bit wr, ill;
    logic [63:0] got_rf, want_rf;
    op = int'(ins[15:12]); rd = int'(ins[11:9]); rs1 = int'(ins[8:6]);
    rs2 = int'(ins[5:3]); imm = int'(ins[7:0]);
    wait_ready();
    Instr_Valid = 1'b1;
    Instruction = ins;
    a = int'(exp_rf[rs1]);
    b = int'(exp_rf[rs2]);
    wr = (op >= 1) && (op <= 9);
    ill = (op >= 10);
    res = ref_result(op, a, b, imm);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold_valid) Instr_Valid = 1'b0;
    if (check_gap) check("accept_gap", 32'(acc - last_acc), 32'd3);
    last_acc = acc;
    for (int i = 0; i < 8; i++) begin
      got_rf[i*8 +: 8] = rf[i];
      want_rf[i*8 +: 8] = exp_rf[i];
    end
    check("regfile_lo", got_rf[31:0], want_rf[31:0]);
    check("regfile_hi", got_rf[63:32], want_rf[63:32]);
    check("ready_busy", 32'(Instr_Ready), 32'd0);
    check("rd_addr1", 32'(Read_Register_1), 32'(rs1));
    check("rd_addr2", 32'(Read_Register_2), 32'(rs2));
    @(posedge clk);
    #1;
    check("done_early", 32'(Done), 32'd0);
    check("write_early", 32'(reg_Write), 32'd0);
    @(posedge clk);
    #1;
    if (wr) begin
      exp_last = 8'(res);
      exp_zero = (res == 0);
    end
    check("done", 32'(Done), 32'd1);
    check("illegal", 32'(Illegal), 32'(ill));
    check("reg_write", 32'(reg_Write), 32'(wr));
    check("zero", 32'(Zero), 32'(exp_zero));
    if (wr || ill) check("write_data", 32'(Write_Data), 32'(exp_last));
    if (wr) begin
      check("write_reg", 32'(Write_Register), 32'(rd));
      exp_rf[rd] = 8'(res);
    end
  endtask

  initial begin
    bit prev_hold;
    bit hold;
    logic [15:0] ins;
    // reset state
    #12;
    check("rst_ready", 32'(Instr_Ready), 32'd0);
    check("rst_write", 32'(reg_Write), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_illegal", 32'(Illegal), 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);
    check("rst_addrs", {23'd0, Read_Register_1, Read_Register_2, Write_Register}, 32'd0);
    check("rst_wdata", 32'(Write_Data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(Instr_Ready), 32'd1);

    // directed sequence
    run_instr(enc_li(3, 8'h5A), 1'b0, 1'b0);
    run_instr(enc_li(1, 8'hF0), 1'b0, 1'b0);
    run_instr(enc_li(2, 8'h20), 1'b0, 1'b0);
    run_instr(enc(1, 4, 1, 2), 1'b0, 1'b0);
    run_instr(enc(2, 5, 2, 1), 1'b0, 1'b0);
    run_instr(enc(3, 6, 1, 1), 1'b0, 1'b0);
    run_instr(enc_li(1, 8'h01), 1'b1, 1'b0);
    run_instr(enc(1, 1, 1, 1), 1'b0, 1'b1);
    run_instr(enc(2, 7, 2, 2), 1'b0, 1'b0);
    run_instr(enc(0, 0, 0, 0), 1'b0, 1'b0);
    run_instr(enc(12, 3, 1, 2), 1'b0, 1'b0);
    run_instr(enc_li(2, 8'h00), 1'b0, 1'b0);

    // reset while in READ of ADD r2, r1, r1
    wait_ready();
    Instr_Valid = 1'b1;
    Instruction = enc(1, 2, 1, 1);
    @(posedge clk);
    #1;
    Instr_Valid = 1'b0;
    reset = 1'b0;
    exp_zero = 1'b0;
    exp_last = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rstmid_write", 32'(reg_Write), 32'd0);
      check("rstmid_done", 32'(Done), 32'd0);
      check("rstmid_ready", 32'(Instr_Ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rel_write", 32'(reg_Write), 32'd0);
      check("rel_done", 32'(Done), 32'd0);
    end
    check("rel_ready", 32'(Instr_Ready), 32'd1);
    check("r2_untouched", 32'(rf[2]), 32'(exp_rf[2]));
    run_instr(enc(7, 0, 2, 0), 1'b0, 1'b0);

    // randomized stream, occasionally back-to-back
    prev_hold = 1'b0;
    for (int n = 0; n < 80; n++) begin
      ins = 16'($urandom());
      if ($urandom_range(0, 7) == 0) ins[15:12] = 4'(10 + $urandom_range(0, 5));
      else ins[15:12] = 4'($urandom_range(0, 9));
      hold = ($urandom_range(0, 2) == 0) && (n != 79);
      run_instr(ins, hold, prev_hold);
      prev_hold = hold;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) check("final_rf", 32'(rf[i]), 32'(exp_rf[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_exec_ctrl.md
Name: instr_exec_ctrl

Overview:
- Multi-cycle execute controller that sits directly upstream of the 8x8-bit register file.
- Accepts one 16-bit instruction per valid/ready handshake and drives both register-file read addresses.
- Captures the returned operands, computes an 8-bit result and issues one write-back (reg_Write, Write_Register, Write_Data).
- Throughput is one instruction per 3 cycles; a read-after-write hazard is impossible by construction.

Parameters:
- WORD_LENGTH, 8, data width of operands, result and Write_Data.
- ADDR_LENGTH, 3, register address width (8 registers).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Instr_Valid  input  1  instruction present on Instruction.
- Instruction  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LI only).
- Instr_Ready  output  1  controller can accept an instruction.
- Read_Register_1  output  ADDR_LENGTH  to register file, equals latched rs1.
- Read_Register_2  output  ADDR_LENGTH  to register file, equals latched rs2.
- Read_Data_1  input  WORD_LENGTH  combinational data from register file port 1.
- Read_Data_2  input  WORD_LENGTH  combinational data from register file port 2.
- reg_Write  output  1  write enable to register file.
- Write_Register  output  ADDR_LENGTH  destination, equals latched rd.
- Write_Data  output  WORD_LENGTH  registered result.
- Done  output  1  one-cycle pulse at instruction completion.
- Illegal  output  1  one-cycle pulse, coincident with Done, for an undefined opcode.
- Zero  output  1  sticky flag, set when the last written result was 0x00.

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - state = IDLE, all latched fields = 0, result register = 0.
  - Instr_Ready = 0 during reset and 1 in the first cycle after release.
  - reg_Write, Done, Illegal and Zero = 0; address outputs = 0.
- State IDLE:
  - Instr_Ready = 1.
  - On a clock edge with Instr_Valid = 1, latch Instruction and go to READ.
  - Instr_Valid is ignored in every other state.
- State READ:
  - Instr_Ready = 0; Read_Register_1/2 are driven from the latched rs1/rs2.
  - At the next edge, compute from Read_Data_1 (A) and Read_Data_2 (B), register the result, and go to WB.
- State WB:
  - Done = 1 for one cycle.
  - reg_Write = 1 only for legal writing opcodes; Write_Register = rd; Write_Data = result register.
  - The register file captures the write at the edge leaving WB.
  - Next state is always IDLE.
- Timing:
  - Accept edge E0 -> reg_Write/Done high in cycle E2–E3.
  - Next accept no earlier than E3; a following instruction reads the updated value.
- Opcodes (all arithmetic modulo 2^WORD_LENGTH, carry/borrow discarded):
  - 0 NOP: no write, Done only.
  - 1 ADD: A+B. 2 SUB: A-B. 3 AND: A&B. 4 OR: A|B. 5 XOR: A^B.
  - 6 LI: imm.
  - 7 MOV: A.
  - 8 SHL: A << B[2:0]. 9 SHR: A >> B[2:0] (logical).
  - 10–15: Illegal pulse with Done; no write; result register unchanged.
- Zero flag:
  - Updated only in a WB cycle with reg_Write = 1; becomes 1 when Write_Data = 0, else 0.
  - Holds its value otherwise.
- Output stability: Write_Register, Write_Data and the read addresses hold their last values outside WB/READ. Only reg_Write qualifies a write.
- rd = rs1 or rs2 is legal: operands are captured before the write.
- Reset asserted mid-instruction: the instruction is abandoned, no write occurs, and no Done is generated.

Test Plan:
- Reset release, then LI r3, 0x5A (0x6_6_5A -> opcode 6, rd 3) -> reg_Write = 1 two cycles after accept, Write_Register = 3, Write_Data = 0x5A, Done pulse, Zero = 0.
- With r1 = 0xF0 and r2 = 0x20: ADD r4, r1, r2 -> Write_Data = 0x10 (wrap). SUB r5, r2, r1 -> 0x30. AND r6, r1, r1 -> 0xF0.
- Back-to-back, Instr_Valid held high: LI r1, 0x01 then ADD r1, r1, r1.
  - Second accept occurs exactly 3 cycles after the first.
  - Second write = 0x02, confirming no RAW hazard.
- SUB r7, r2, r2 -> Write_Data = 0x00 and Zero = 1. A following NOP -> Done with no reg_Write; Zero stays 1.
- Opcode 0xC -> Done and Illegal pulse together; reg_Write stays 0; register contents unchanged.
- Reset pulled low while in READ of ADD r2, ... -> no reg_Write, no Done; after release Instr_Ready = 1 and r2 reads back 0x00.
